// File: rtl/cube_color_pkg.sv
//------------------------------------------------------------------------------
// Module   : cube_color_pkg
// Brief    : Colour codes and scanner FSM encoding shared by the facelet scanner.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cube_color_pkg;

    localparam int COLOR_W    = 3;
    localparam int NUM_COLORS = 6;

    localparam logic [COLOR_W-1:0] WHITE   = 3'd0;
    localparam logic [COLOR_W-1:0] YELLOW  = 3'd1;
    localparam logic [COLOR_W-1:0] RED     = 3'd2;
    localparam logic [COLOR_W-1:0] ORANGE  = 3'd3;
    localparam logic [COLOR_W-1:0] GREEN   = 3'd4;
    localparam logic [COLOR_W-1:0] BLUE    = 3'd5;
    localparam logic [COLOR_W-1:0] UNKNOWN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/color_match_vector.sv
//------------------------------------------------------------------------------
// Module   : color_match_vector
// Brief    : Combinational compare of one pixel against the six reference
//            colours; tolerance window enabled by MATCH_TOLERANCE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module color_match_vector
    import cube_color_pkg::*;
#(
    parameter int N      = 8,
    parameter int COLOR0 = 23,
    parameter int COLOR1 = 70,
    parameter int COLOR2 = 117,
    parameter int COLOR3 = 164,
    parameter int COLOR4 = 211,
    parameter int COLOR5 = 250,
    parameter int TOL    = 4
) (
    input  logic [N-1:0]          i_pixel,
    output logic [NUM_COLORS-1:0] o_hit
);

`ifdef MATCH_TOLERANCE_EN
    localparam bit TOL_ENABLED = 1'b1;
`else
    localparam bit TOL_ENABLED = 1'b0;
`endif
    // A zero window degenerates to exact equality.
    localparam int TOL_EFF = TOL_ENABLED ? TOL : 0;

    localparam logic [N:0] REF_VAL [NUM_COLORS] = '{
        (N+1)'(COLOR0), (N+1)'(COLOR1), (N+1)'(COLOR2),
        (N+1)'(COLOR3), (N+1)'(COLOR4), (N+1)'(COLOR5)
    };

    logic [N:0] w_pix;
    assign w_pix = {1'b0, i_pixel};

    generate
        for (genvar g = 0; g < NUM_COLORS; g++) begin : g_match
            logic [N:0] w_diff;
            assign w_diff   = (w_pix >= REF_VAL[g]) ? (w_pix - REF_VAL[g])
                                                    : (REF_VAL[g] - w_pix);
            assign o_hit[g] = (w_diff <= (N+1)'(TOL_EFF));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/facelet_color_scanner.sv
//------------------------------------------------------------------------------
// Module   : facelet_color_scanner
// Brief    : Classifies PIXELS samples per facelet into one of six colours and
//            emits one code per facelet; optional MATCH_TOLERANCE_EN window.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module facelet_color_scanner
    import cube_color_pkg::*;
#(
    parameter int N        = 8,
    parameter int PIXELS   = 64,
    parameter int FACELETS = 9,
    parameter int THRESH   = 32,
    parameter int COLOR0   = 23,
    parameter int COLOR1   = 70,
    parameter int COLOR2   = 117,
    parameter int COLOR3   = 164,
    parameter int COLOR4   = 211,
    parameter int COLOR5   = 250,
    parameter int TOL      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [N-1:0]       pixel_value,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    output logic               busy,
    output logic               result_valid,
    output logic [3:0]         result_index,
    output logic [COLOR_W-1:0] result_color,
    output logic               done
);

    localparam int CW = $clog2(PIXELS + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]      cnt_q [NUM_COLORS];
    logic [CW-1:0]      cnt_d [NUM_COLORS];
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         res_index_q, res_index_d;
    logic [COLOR_W-1:0] res_color_q, res_color_d;

    logic [NUM_COLORS-1:0] w_hit, w_first_hit;
    logic [CW-1:0]         w_best_cnt;
    logic [COLOR_W-1:0]    w_best_code;

    color_match_vector #(
        .N(N), .COLOR0(COLOR0), .COLOR1(COLOR1), .COLOR2(COLOR2),
        .COLOR3(COLOR3), .COLOR4(COLOR4), .COLOR5(COLOR5), .TOL(TOL)
    ) u_match (
        .i_pixel (pixel_value),
        .o_hit   (w_hit)
    );

    // Isolate the lowest set bit so overlapping windows credit one colour only.
    assign w_first_hit = w_hit & (~w_hit + {{(NUM_COLORS-1){1'b0}}, 1'b1});

    always_comb begin
        w_best_cnt  = cnt_q[0];
        w_best_code = WHITE;
        for (int k = 1; k < NUM_COLORS; k++) begin
            if (cnt_q[k] > w_best_cnt) begin
                w_best_cnt  = cnt_q[k];
                w_best_code = COLOR_W'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        res_index_d = res_index_q;
        res_color_d = res_color_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = 4'd0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pix_cnt_d = '0;
                for (int k = 0; k < NUM_COLORS; k++) cnt_d[k] = '0;
                state_d   = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (pixel_valid) begin
                    pix_cnt_d = pix_cnt_q + CW'(1);
                    for (int k = 0; k < NUM_COLORS; k++) begin
                        if (w_first_hit[k]) cnt_d[k] = cnt_q[k] + CW'(1);
                    end
                    if (pix_cnt_q == CW'(PIXELS - 1)) state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                res_index_d = idx_q;
                res_color_d = (w_best_cnt < CW'(THRESH)) ? UNKNOWN : w_best_code;
                state_d     = ST_EMIT;
            end
            ST_EMIT: begin
                if (idx_q == 4'(FACELETS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: begin
                idx_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Cancel overrides every transition and leaves the last result intact.
        if (abort) begin
            state_d     = ST_IDLE;
            idx_d       = 4'd0;
            res_index_d = res_index_q;
            res_color_d = res_color_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pix_cnt_q   <= '0;
            cnt_q       <= '{default: '0};
            idx_q       <= 4'd0;
            res_index_q <= 4'd0;
            res_color_q <= '0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            res_index_q <= res_index_d;
            res_color_q <= res_color_d;
        end
    end

    assign pixel_ready  = (state_q == ST_ACCUM);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_EMIT) && !abort;
    assign done         = (state_q == ST_DONE) && !abort;
    assign result_index = res_index_q;
    assign result_color = res_color_q;

endmodule

`default_nettype wire
